// File: rtl/voice_phase_accumulator_pkg.sv
// Shared sizing defaults and CPU register-select encodings for the voice phase accumulator.
package voice_phase_accumulator_pkg;

  localparam int DEF_VW         = 4;
  localparam int DEF_FRAC_W     = 8;
  localparam int DEF_INT_W      = 16;
  localparam int DEF_PITCH_W    = 16;
  localparam int DEF_NUM_VOICES = 2 ** DEF_VW;
  localparam int DEF_PHASE_W    = DEF_INT_W + DEF_FRAC_W;

  typedef enum logic [1:0] {
    SEL_PITCH = 2'd0,
    SEL_LOOP  = 2'd1,
    SEL_END   = 2'd2,
    SEL_KEY   = 2'd3
  } wr_sel_t;

endpackage

// File: rtl/voice_phase_accumulator_phase_wrap_alu.sv
// Combinational phase step: add pitch, compare against end point, then loop back or park at end.
module phase_wrap_alu #(
  parameter int FRAC_W  = 8,
  parameter int INT_W   = 16,
  parameter int PITCH_W = 16
) (
  input  logic [INT_W+FRAC_W-1:0] phase,
  input  logic [PITCH_W-1:0]      pitch,
  input  logic [INT_W-1:0]        loop_pt,
  input  logic [INT_W-1:0]        end_pt,
  output logic [INT_W+FRAC_W-1:0] next_phase,
  output logic                    end_hit_oneshot
);

  localparam int PHASE_W = INT_W + FRAC_W;

  logic [PHASE_W:0]   sum;
  logic [INT_W:0]     sum_int;
  logic [INT_W-1:0]   span;
  logic [PHASE_W-1:0] wrapped;

  // The extra top bit keeps the adder carry, so an overflowing sum always compares as past the end.
  assign sum     = {1'b0, phase} + {{(PHASE_W + 1 - PITCH_W){1'b0}}, pitch};
  assign sum_int = sum[PHASE_W:FRAC_W];
  assign span    = end_pt - loop_pt;
  assign wrapped = sum[PHASE_W-1:0] - {span, {FRAC_W{1'b0}}};

  always_comb begin
    next_phase      = sum[PHASE_W-1:0];
    end_hit_oneshot = 1'b0;
    if (sum_int >= {1'b0, end_pt}) begin
      if (loop_pt < end_pt) begin
        next_phase = wrapped;
      end else begin
        next_phase      = {end_pt, {FRAC_W{1'b0}}};
        end_hit_oneshot = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_phase_accumulator.sv
// Time-multiplexed per-voice phase generator: one voice per slot_en, registered ROM address one cycle later.
// CPU key writes to the serviced voice win over the accumulator result; outputs always show pre-write state.
module voice_phase_accumulator
  import voice_phase_accumulator_pkg::*;
#(
  parameter int VW      = DEF_VW,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int INT_W   = DEF_INT_W,
  parameter int PITCH_W = DEF_PITCH_W
) (
  input  logic             CK,
  input  logic             nCL,
  input  logic             slot_en,
  input  logic             wr_en,
  input  logic [VW-1:0]    wr_voice,
  input  logic [1:0]       wr_sel,
  input  logic [15:0]      wr_data,
  output logic [INT_W-1:0] rom_addr,
  output logic [VW-1:0]    voice_out,
  output logic             addr_valid,
  output logic             sync
);

  localparam int NUM_VOICES = 2 ** VW;
  localparam int PHASE_W    = INT_W + FRAC_W;

  logic [PHASE_W-1:0] phase_q  [NUM_VOICES];
  logic [PITCH_W-1:0] pitch_q  [NUM_VOICES];
  logic [INT_W-1:0]   loop_q   [NUM_VOICES];
  logic [INT_W-1:0]   end_q    [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q;
  logic [VW-1:0]      slot;

  logic [PHASE_W-1:0] alu_next;
  logic               alu_oneshot;

  phase_wrap_alu #(
    .FRAC_W  (FRAC_W),
    .INT_W   (INT_W),
    .PITCH_W (PITCH_W)
  ) u_alu (
    .phase           (phase_q[slot]),
    .pitch           (pitch_q[slot]),
    .loop_pt         (loop_q[slot]),
    .end_pt          (end_q[slot]),
    .next_phase      (alu_next),
    .end_hit_oneshot (alu_oneshot)
  );

  always_ff @(posedge CK or negedge nCL) begin
    if (!nCL) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        pitch_q[i] <= '0;
        loop_q[i]  <= '0;
        end_q[i]   <= '0;
      end
      active_q   <= '0;
      slot       <= '0;
      rom_addr   <= '0;
      voice_out  <= '0;
      addr_valid <= 1'b0;
      sync       <= 1'b0;
    end else begin
      if (slot_en) begin
        slot       <= slot + 1'b1;
        rom_addr   <= phase_q[slot][PHASE_W-1:FRAC_W];
        voice_out  <= slot;
        addr_valid <= active_q[slot];
        sync       <= (slot == '0);
        if (active_q[slot]) begin
          phase_q[slot] <= alu_next;
          if (alu_oneshot) active_q[slot] <= 1'b0;
        end
      end
      // Placed after the service update so a same-voice key write is the last assignment and wins.
      if (wr_en) begin
        case (wr_sel_t'(wr_sel))
          SEL_PITCH: pitch_q[wr_voice] <= PITCH_W'(wr_data);
          SEL_LOOP:  loop_q[wr_voice]  <= INT_W'(wr_data);
          SEL_END:   end_q[wr_voice]   <= INT_W'(wr_data);
          SEL_KEY: begin
            active_q[wr_voice] <= wr_data[0];
            if (wr_data[0]) phase_q[wr_voice] <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_phase_accumulator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a per-voice arithmetic model.
module tb_voice_phase_accumulator;
  import voice_phase_accumulator_pkg::*;

  logic        CK = 1'b0;
  logic        nCL;
  logic        slot_en;
  logic        wr_en;
  logic [3:0]  wr_voice;
  logic [1:0]  wr_sel;
  logic [15:0] wr_data;
  logic [15:0] rom_addr;
  logic [3:0]  voice_out;
  logic        addr_valid;
  logic        sync;

  voice_phase_accumulator dut (
    .CK         (CK),
    .nCL        (nCL),
    .slot_en    (slot_en),
    .wr_en      (wr_en),
    .wr_voice   (wr_voice),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .rom_addr   (rom_addr),
    .voice_out  (voice_out),
    .addr_valid (addr_valid),
    .sync       (sync)
  );

  always #5 CK = ~CK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each voice as plain numbers (phase in 1/256 address units).
  longint      m_phase  [16];
  longint      m_pitch  [16];
  longint      m_loop   [16];
  longint      m_end    [16];
  bit          m_active [16];
  int          m_slot;
  longint      exp_rom;
  int          exp_voice;
  bit          exp_valid;
  bit          exp_sync;
  longint      cap_rom   [16];
  bit          cap_valid [16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_phase[i] = 0; m_pitch[i] = 0; m_loop[i] = 0; m_end[i] = 0; m_active[i] = 0;
      cap_rom[i] = 0; cap_valid[i] = 0;
    end
    m_slot = 0; exp_rom = 0; exp_voice = 0; exp_valid = 0; exp_sync = 0;
  endtask

  // One clock with the given strobes; updates the model and captures the serviced voice's output.
  task automatic step(input bit se, input bit we, input logic [3:0] v,
                      input logic [1:0] sel, input logic [15:0] d);
    longint n;
    int s;
    slot_en = se; wr_en = we; wr_voice = v; wr_sel = sel; wr_data = d;
    @(posedge CK);
    if (se) begin
      s = m_slot;
      exp_rom = m_phase[s] / 256;
      exp_voice = s;
      exp_valid = m_active[s];
      exp_sync = (s == 0);
      if (m_active[s]) begin
        n = m_phase[s] + m_pitch[s];
        if (n / 256 < m_end[s]) m_phase[s] = n % (64'd1 << 24);
        else if (m_loop[s] < m_end[s]) m_phase[s] = (n - (m_end[s] - m_loop[s]) * 256) % (64'd1 << 24);
        else begin
          m_phase[s] = m_end[s] * 256;
          m_active[s] = 0;
        end
      end
      m_slot = (s + 1) % 16;
    end
    if (we) begin
      case (sel)
        2'd0: m_pitch[v] = d;
        2'd1: m_loop[v] = d;
        2'd2: m_end[v] = d;
        default: begin
          if (d[0]) begin m_phase[v] = 0; m_active[v] = 1; end
          else m_active[v] = 0;
        end
      endcase
    end
    #1;
    slot_en = 0; wr_en = 0;
    if (se) begin
      cap_rom[exp_voice] = rom_addr;
      cap_valid[exp_voice] = addr_valid;
    end
  endtask

  task automatic slots(input int n);
    repeat (n) step(1'b1, 1'b0, 4'd0, 2'd0, 16'd0);
  endtask

  task automatic wr(input logic [3:0] v, input logic [1:0] sel, input logic [15:0] d);
    step(1'b0, 1'b1, v, sel, d);
  endtask

  task automatic test_reset();
    nCL = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    n_cmp++; if (rom_addr !== 16'h0)  begin n_bad++; $display("FAIL reset_rom got=%h want=0", rom_addr); end
    n_cmp++; if (voice_out !== 4'h0)  begin n_bad++; $display("FAIL reset_voice got=%h want=0", voice_out); end
    n_cmp++; if (addr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", addr_valid); end
    n_cmp++; if (sync !== 1'b0)       begin n_bad++; $display("FAIL reset_sync got=%b want=0", sync); end
    nCL = 1'b1;
    model_reset();
    wr(4'd3, SEL_END, 16'hFFFF);
    wr(4'd3, SEL_PITCH, 16'h0400);
    wr(4'd3, SEL_KEY, 16'h0001);
    slots(16 + 5);
    // Asynchronous assertion mid-frame, away from any clock edge.
    #2 nCL = 1'b0;
    #1;
    n_cmp++; if (rom_addr !== 16'h0 || addr_valid !== 1'b0 || voice_out !== 4'h0 || sync !== 1'b0) begin
      n_bad++; $display("FAIL async_reset rom=%h voice=%h valid=%b sync=%b want all 0", rom_addr, voice_out, addr_valid, sync);
    end
    @(negedge CK);
    nCL = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      slots(1);
      n_cmp++;
      if (voice_out !== 4'(i) || addr_valid !== 1'b0 || rom_addr !== 16'h0 || sync !== (i == 0)) begin
        n_bad++;
        $display("FAIL post_reset_slot%0d voice=%h valid=%b rom=%h sync=%b want voice=%h valid=0 rom=0 sync=%b",
                 i, voice_out, addr_valid, rom_addr, sync, 4'(i), (i == 0));
      end
    end
  endtask

  task automatic test_accumulate();
    longint want [4];
    want = '{0, 1, 3, 4};
    wr(4'd3, SEL_PITCH, 16'h0180);
    wr(4'd3, SEL_LOOP,  16'h0010);
    wr(4'd3, SEL_END,   16'h0100);
    wr(4'd3, SEL_KEY,   16'h0001);
    for (int f = 0; f < 4; f++) begin
      slots(16);
      n_cmp++;
      if (cap_rom[3] !== want[f] || cap_valid[3] !== 1'b1) begin
        n_bad++; $display("FAIL accumulate_frame%0d rom=%h valid=%b want rom=%h valid=1", f, cap_rom[3], cap_valid[3], want[f]);
      end
    end
  endtask

  task automatic test_loop_wrap();
    wr(4'd3, SEL_END,   16'hFFFF);
    wr(4'd3, SEL_LOOP,  16'h0010);
    wr(4'd3, SEL_PITCH, 16'h7FC0);
    wr(4'd3, SEL_KEY,   16'h0001);
    slots(32);
    wr(4'd3, SEL_PITCH, 16'h0100);
    wr(4'd3, SEL_END,   16'h0100);
    slots(16);
    n_cmp++; if (cap_rom[3] !== 64'h00FF) begin n_bad++; $display("FAIL loop_pre rom=%h want=00ff", cap_rom[3]); end
    slots(16);
    n_cmp++; if (cap_rom[3] !== 64'h0010 || cap_valid[3] !== 1'b1) begin
      n_bad++; $display("FAIL loop_wrap rom=%h valid=%b want rom=0010 valid=1", cap_rom[3], cap_valid[3]);
    end
  endtask

  task automatic test_oneshot();
    wr(4'd3, SEL_END,   16'h0020);
    wr(4'd3, SEL_LOOP,  16'h0020);
    wr(4'd3, SEL_PITCH, 16'h0FE0);
    wr(4'd3, SEL_KEY,   16'h0001);
    slots(32);
    wr(4'd3, SEL_PITCH, 16'h0080);
    slots(16);
    n_cmp++; if (cap_rom[3] !== 64'h001F || cap_valid[3] !== 1'b1) begin
      n_bad++; $display("FAIL oneshot_last rom=%h valid=%b want rom=001f valid=1", cap_rom[3], cap_valid[3]);
    end
    for (int f = 0; f < 2; f++) begin
      slots(16);
      n_cmp++;
      if (cap_rom[3] !== 64'h0020 || cap_valid[3] !== 1'b0) begin
        n_bad++; $display("FAIL oneshot_parked%0d rom=%h valid=%b want rom=0020 valid=0", f, cap_rom[3], cap_valid[3]);
      end
    end
  endtask

  task automatic test_collision();
    int guard;
    wr(4'd5, SEL_END,   16'hFFFF);
    wr(4'd5, SEL_LOOP,  16'h0000);
    wr(4'd5, SEL_PITCH, 16'h2000);
    wr(4'd5, SEL_KEY,   16'h0001);
    slots(32);
    guard = 0;
    while (m_slot != 5 && guard < 16) begin slots(1); guard++; end
    step(1'b1, 1'b1, 4'd5, SEL_KEY, 16'h0001);
    n_cmp++; if (rom_addr !== 16'h0040 || voice_out !== 4'd5 || addr_valid !== 1'b1) begin
      n_bad++; $display("FAIL key_collision rom=%h voice=%h valid=%b want rom=0040 voice=5 valid=1", rom_addr, voice_out, addr_valid);
    end
    slots(16);
    n_cmp++; if (cap_rom[5] !== 64'h0000 || cap_valid[5] !== 1'b1) begin
      n_bad++; $display("FAIL key_restart rom=%h valid=%b want rom=0000 valid=1", cap_rom[5], cap_valid[5]);
    end
    // Pitch rewritten on the very cycle voice 5 is serviced: that visit still uses the old pitch.
    guard = 0;
    while (m_slot != 5 && guard < 16) begin slots(1); guard++; end
    step(1'b1, 1'b1, 4'd5, SEL_PITCH, 16'h4000);
    n_cmp++; if (rom_addr !== 16'h0020) begin n_bad++; $display("FAIL pitch_collision rom=%h want=0020", rom_addr); end
    slots(16);
    n_cmp++; if (cap_rom[5] !== 64'h0040) begin n_bad++; $display("FAIL pitch_old_used rom=%h want=0040", cap_rom[5]); end
    slots(16);
    n_cmp++; if (cap_rom[5] !== 64'h0080) begin n_bad++; $display("FAIL pitch_new_used rom=%h want=0080", cap_rom[5]); end
  endtask

  task automatic test_carry();
    wr(4'd7, SEL_END,   16'hFFFF);
    wr(4'd7, SEL_LOOP,  16'h0000);
    wr(4'd7, SEL_PITCH, 16'hFFFE);
    wr(4'd7, SEL_KEY,   16'h0001);
    slots(16 * 256);
    wr(4'd7, SEL_PITCH, 16'h0200);
    slots(16);
    n_cmp++; if (cap_rom[7] !== 64'hFFFE) begin n_bad++; $display("FAIL carry_pre rom=%h want=fffe", cap_rom[7]); end
    slots(16);
    n_cmp++; if (cap_rom[7] !== 64'h0001 || cap_valid[7] !== 1'b1) begin
      n_bad++; $display("FAIL carry_wrap rom=%h valid=%b want rom=0001 valid=1", cap_rom[7], cap_valid[7]);
    end
  endtask

  task automatic test_zero_pitch();
    wr(4'd9, SEL_END,   16'h0100);
    wr(4'd9, SEL_PITCH, 16'h0300);
    wr(4'd9, SEL_KEY,   16'h0001);
    slots(32);
    wr(4'd9, SEL_PITCH, 16'h0000);
    for (int f = 0; f < 2; f++) begin
      slots(16);
      n_cmp++; if (cap_rom[9] !== 64'h0006 || cap_valid[9] !== 1'b1) begin
        n_bad++; $display("FAIL zero_pitch%0d rom=%h valid=%b want rom=0006 valid=1", f, cap_rom[9], cap_valid[9]);
      end
    end
  endtask

  task automatic test_random();
    bit se, we;
    logic [3:0] v;
    logic [1:0] sel;
    logic [15:0] d;
    for (int i = 0; i < 3000; i++) begin
      se  = ($urandom % 4) != 0;
      we  = ($urandom % 3) == 0;
      v   = 4'($urandom);
      sel = 2'($urandom);
      case (sel)
        2'd0:    d = 16'($urandom_range(0, 16'h0600));
        2'd3:    d = {15'd0, ($urandom % 4) != 0};
        default: d = 16'($urandom_range(0, 16'h0200));
      endcase
      step(se, we, v, sel, d);
      n_cmp++;
      if (rom_addr !== 16'(exp_rom) || voice_out !== 4'(exp_voice) || addr_valid !== exp_valid || sync !== exp_sync) begin
        n_bad++;
        $display("FAIL random_cyc%0d rom=%h voice=%h valid=%b sync=%b want rom=%h voice=%h valid=%b sync=%b",
                 i, rom_addr, voice_out, addr_valid, sync, 16'(exp_rom), 4'(exp_voice), exp_valid, exp_sync);
      end
    end
  endtask

  initial begin
    nCL = 1'b0; slot_en = 0; wr_en = 0; wr_voice = 0; wr_sel = 0; wr_data = 0;
    model_reset();
    test_reset();
    test_accumulate();
    test_loop_wrap();
    test_oneshot();
    test_collision();
    test_carry();
    test_zero_pitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
